// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array output path.
package sa_pkg;

  localparam int N           = 4;
  localparam int DW          = 32;
  localparam int DEPTH       = 16;
  localparam int FRAME_ELEMS = N * N;

  // Row/column index inside the 4x4 array.
  typedef logic [1:0] sa_idx_t;

  // One tagged PE result as it travels through the drain FIFO.
  typedef struct packed {
    logic [DW-1:0] data;
    sa_idx_t       row;
    sa_idx_t       col;
    logic          last;
  } sa_result_t;

  // Array controller phases, shared so both sides decode the same encoding.
  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_LOAD = 2'd1,
    CTRL_PUMP = 2'd2,
    CTRL_OUT  = 2'd3
  } sa_ctrl_state_e;

  // Drain-side capture state.
  typedef enum logic {
    DRAIN_IDLE    = 1'b0,
    DRAIN_COLLECT = 1'b1
  } sa_drain_state_e;

endpackage

// File: rtl/sa_sync_fifo.sv
// Synchronous FIFO with a masked head output: rdata_o is zero while empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sa_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sa_result_drain.sv
// Captures a 4x4 result frame from the systolic array, tags each element
// with (row, col, last) and streams it out through a 16-entry FIFO.
//
// Output handshake: an element transfers on a rising clk edge where
// m_valid & m_ready are both 1. m_valid never depends on m_ready, and
// m_data/m_row/m_col/m_last hold stable while m_valid & !m_ready.
module sa_result_drain
  import sa_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            sa_out_en,
  input  logic [1:0]      sa_row_out,
  input  logic [DW-1:0]   sa_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic [1:0]      m_row,
  output logic [1:0]      m_col,
  output logic            m_last,
  output logic            frame_done,
  output logic            overflow,
  output logic            seq_err,
  output logic            busy,
  output sa_drain_state_e dbg_state_o
);

  localparam int AW = $clog2(DEPTH);

  sa_drain_state_e state_q, state_d;
  sa_idx_t         col_cnt_q, col_cnt_d;
  logic [3:0]      elem_cnt_q, elem_cnt_d;
  logic            overflow_q, seq_err_q, frame_done_q;

  sa_result_t      wr_entry, head;
  logic            fifo_full, fifo_empty, pop, is_last;
  logic [AW:0]     fifo_count;

  assign is_last  = (elem_cnt_q == 4'(FRAME_ELEMS - 1));
  assign wr_entry = '{data: sa_data, row: sa_row_out, col: col_cnt_q, last: is_last};
  assign pop      = m_valid & m_ready;

  sa_sync_fifo #(
    .WIDTH ($bits(sa_result_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (sa_out_en),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_valid     = ~fifo_empty;
  assign m_data      = head.data;
  assign m_row       = head.row;
  assign m_col       = head.col;
  assign m_last      = head.last;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign seq_err     = seq_err_q;
  assign busy        = (state_q == DRAIN_COLLECT) | (fifo_count != '0) | sa_out_en;
  assign dbg_state_o = state_q;

  // Next-state logic: counters advance on every strobe, even a dropped one,
  // so tags after an overflow stay aligned with the array.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    elem_cnt_d = elem_cnt_q;
    if (sa_out_en) begin
      col_cnt_d  = col_cnt_q + 2'd1;
      elem_cnt_d = elem_cnt_q + 4'd1;
    end
    unique case (state_q)
      DRAIN_IDLE:    if (sa_out_en) state_d = is_last ? DRAIN_IDLE : DRAIN_COLLECT;
      DRAIN_COLLECT: if (sa_out_en && is_last) state_d = DRAIN_IDLE;
      default:       state_d = DRAIN_IDLE;
    endcase
  end

  // State, counters, sticky error flags and the frame_done pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= DRAIN_IDLE;
      col_cnt_q    <= '0;
      elem_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      elem_cnt_q   <= elem_cnt_d;
      if (sa_out_en && fifo_full && !pop)            overflow_q <= 1'b1;
      if (sa_out_en && (sa_row_out != elem_cnt_q[3:2])) seq_err_q <= 1'b1;
      frame_done_q <= pop & head.last;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: one task per scenario.
module tb_sa_result_drain;
  import sa_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            en = 1'b0;
  logic [1:0]      row = 2'd0;
  logic [31:0]     dat = 32'd0;
  logic            rdy = 1'b0;
  logic            m_valid, m_last, frame_done, overflow, seq_err, busy;
  logic [31:0]     m_data;
  logic [1:0]      m_row, m_col;
  sa_drain_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] exp_q[$];

  sa_result_drain dut (
    .clk         (clk),
    .rstn        (rstn),
    .sa_out_en   (en),
    .sa_row_out  (row),
    .sa_data     (dat),
    .m_valid     (m_valid),
    .m_ready     (rdy),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_col       (m_col),
    .m_last      (m_last),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .seq_err     (seq_err),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  wire [36:0] obs = {m_row, m_col, m_data, m_last};

  function automatic logic [36:0] exp_elem(input int r, input int c, input int d, input logic l);
    return {2'(r), 2'(c), 32'(d), l};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; row = 2'd0; dat = 32'd0; rdy = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m_valid, m_data, m_row, m_col, m_last, frame_done, overflow, seq_err, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b d=%h r=%0d c=%0d l=%b fd=%b ov=%b se=%b busy=%b exp all 0",
               m_valid, m_data, m_row, m_col, m_last, frame_done, overflow, seq_err, busy);
    end
    n_cmp++;
    if (dbg_state !== DRAIN_IDLE) begin
      n_err++; $display("FAIL reset_state got %0d exp %0d", dbg_state, DRAIN_IDLE);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; row = 2'(i / 4); dat = 32'(100 + i);
      tick();
      n_cmp++;
      if (m_valid !== 1'b1 || obs !== exp_elem(i / 4, i % 4, 100 + i, i == 15)) begin
        n_err++; $display("FAIL nominal_elem%0d got v=%b %h exp %h", i, m_valid, obs, exp_elem(i / 4, i % 4, 100 + i, i == 15));
      end
      n_cmp++;
      if (frame_done !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL nominal_flags%0d got fd=%b busy=%b exp fd=0 busy=1", i, frame_done, busy);
      end
      n_cmp++;
      if (dbg_state !== ((i == 15) ? DRAIN_IDLE : DRAIN_COLLECT)) begin
        n_err++; $display("FAIL nominal_state%0d got %0d", i, dbg_state);
      end
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (frame_done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL nominal_end got fd=%b v=%b busy=%b exp fd=1 v=0 busy=0", frame_done, m_valid, busy);
    end
    tick();
    n_cmp++;
    if (frame_done !== 1'b0 || overflow !== 1'b0 || seq_err !== 1'b0) begin
      n_err++; $display("FAIL nominal_after got fd=%b ov=%b se=%b exp 0 0 0", frame_done, overflow, seq_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; row = 2'(i / 4); dat = 32'(200 + i);
      tick();
      n_cmp++;
      if (m_valid !== 1'b1 || obs !== exp_elem(0, 0, 200, 1'b0)) begin
        n_err++; $display("FAIL bp_stall%0d got v=%b %h exp head %h", i, m_valid, obs, exp_elem(0, 0, 200, 1'b0));
      end
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL bp_no_overflow got %b exp 0", overflow);
    end
    en = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || obs !== exp_elem(i / 4, i % 4, 200 + i, i == 15)) begin
        n_err++; $display("FAIL bp_drain%0d got v=%b %h exp %h", i, m_valid, obs, exp_elem(i / 4, i % 4, 200 + i, i == 15));
      end
      tick();
    end
    n_cmp++;
    if (m_valid !== 1'b0 || frame_done !== 1'b1) begin
      n_err++; $display("FAIL bp_end got v=%b fd=%b exp v=0 fd=1", m_valid, frame_done);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      en = 1'b1; row = (i < 16) ? 2'(i / 4) : 2'd0; dat = 32'(300 + i);
      tick();
      n_cmp++;
      if (overflow !== (i == 16)) begin
        n_err++; $display("FAIL ovf_flag%0d got %b exp %b", i, overflow, i == 16);
      end
    end
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_err++; $display("FAIL ovf_seq_err got %b exp 0", seq_err);
    end
    en = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || obs !== exp_elem(i / 4, i % 4, 300 + i, i == 15)) begin
        n_err++; $display("FAIL ovf_drain%0d got v=%b %h exp %h", i, m_valid, obs, exp_elem(i / 4, i % 4, 300 + i, i == 15));
      end
      tick();
    end
    n_cmp++;
    if (m_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_dropped got v=%b ov=%b exp v=0 ov=1", m_valid, overflow);
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      automatic int r = (i == 4) ? 2 : i / 4;
      en = 1'b1; row = 2'(r); dat = 32'(400 + i);
      tick();
      n_cmp++;
      if (m_valid !== 1'b1 || obs !== exp_elem(r, i % 4, 400 + i, i == 15)) begin
        n_err++; $display("FAIL seq_elem%0d got v=%b %h exp %h", i, m_valid, obs, exp_elem(r, i % 4, 400 + i, i == 15));
      end
      n_cmp++;
      if (seq_err !== (i >= 4)) begin
        n_err++; $display("FAIL seq_flag%0d got %b exp %b", i, seq_err, i >= 4);
      end
    end
    en = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (seq_err !== 1'b1) begin
      n_err++; $display("FAIL seq_sticky got %b exp 1", seq_err);
    end
  endtask

  task automatic test_back_to_back();
    logic        fd_exp;
    logic [36:0] e;
    int          fd_cnt;
    logic        done;
    do_reset();
    exp_q.delete();
    fd_exp = 1'b0; fd_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      n_cmp++;
      if (frame_done !== fd_exp) begin
        n_err++; $display("FAIL b2b_fd cyc%0d got %b exp %b", cyc, frame_done, fd_exp);
      end
      if (frame_done === 1'b1) fd_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        if (m_valid !== 1'b0) begin
          n_err++; $display("FAIL b2b_empty cyc%0d got v=%b exp 0", cyc, m_valid);
        end
      end else if (m_valid !== 1'b1 || obs !== exp_q[0]) begin
        n_err++; $display("FAIL b2b_head cyc%0d got v=%b %h exp %h", cyc, m_valid, obs, exp_q[0]);
      end
      if (cyc >= 35 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      rdy = (cyc % 2 == 0);
      fd_exp = 1'b0;
      if (exp_q.size() != 0 && rdy) begin
        e = exp_q.pop_front();
        fd_exp = e[0];
      end
      if (cyc < 35 && !(cyc >= 8 && cyc <= 10)) begin
        automatic int ei = (cyc < 8) ? cyc : cyc - 3;
        automatic int f  = ei % 16;
        en = 1'b1; row = 2'(f / 4); dat = 32'(700 + ei);
        exp_q.push_back(exp_elem(f / 4, f % 4, 700 + ei, f == 15));
      end else begin
        en = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL b2b_timeout got %0d left exp 0", exp_q.size());
    end
    n_cmp++;
    if (fd_cnt != 2 || overflow !== 1'b0) begin
      n_err++; $display("FAIL b2b_frames got fd_cnt=%0d ov=%b exp 2 0", fd_cnt, overflow);
    end
    rdy = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; row = 2'(i / 4); dat = 32'(500 + i);
      tick();
    end
    en = 1'b0; rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_cmp++;
    if ({m_valid, busy, overflow, seq_err, frame_done} !== 5'b0 || dbg_state !== DRAIN_IDLE) begin
      n_err++; $display("FAIL rst_mid got v=%b busy=%b ov=%b se=%b fd=%b st=%0d exp all 0",
                        m_valid, busy, overflow, seq_err, frame_done, dbg_state);
    end
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; row = 2'(i / 4); dat = 32'(600 + i);
      tick();
      n_cmp++;
      if (m_valid !== 1'b1 || obs !== exp_elem(i / 4, i % 4, 600 + i, i == 15)) begin
        n_err++; $display("FAIL rst_frame%0d got v=%b %h exp %h", i, m_valid, obs, exp_elem(i / 4, i % 4, 600 + i, i == 15));
      end
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (frame_done !== 1'b1 || seq_err !== 1'b0) begin
      n_err++; $display("FAIL rst_frame_done got fd=%b se=%b exp 1 0", frame_done, seq_err);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_overflow();
    test_seq_err();
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sa_result_drain.md
Name: sa_result_drain

Overview:
- Consumer side of the systolic-array output phase.
- During the output phase the array controller asserts OutputSign and steps row_out 0..3, holding each row for 4 clocks (one PE result per clock, columns 0..3).
- This block captures those 16 results, tags each with (row, col), buffers them in a 16-entry FIFO, and streams them to memory/host over a valid/ready interface.
- The controller cannot stall, so the buffer absorbs a full 4x4 frame with no backpressure on the array side.

Parameters:
- N, 4, array dimension; fixed, since row/col fields are 2 bits.
- DW, 32, width of one PE accumulator result.
- DEPTH, 16, FIFO entries; must be >= N*N.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- sa_out_en  in  1  array output-phase strobe; driven from the controller's OutputSign
- sa_row_out  in  2  row currently presented; driven from the controller's row_out
- sa_data  in  DW  PE result presented this cycle
- m_valid  out  1  output element valid
- m_ready  in  1  downstream accept
- m_data  out  DW  result value
- m_row  out  2  result row index
- m_col  out  2  result column index
- m_last  out  1  marks the 16th element of a frame
- frame_done  out  1  one-cycle pulse on the m_last handshake
- overflow  out  1  sticky: a write was dropped
- seq_err  out  1  sticky: row sequence mismatch
- busy  out  1  collecting or FIFO non-empty

Behaviour:
- Reset (rstn=0 at posedge clk):
  - col_cnt, elem_cnt, FIFO pointers and count are cleared.
  - All outputs are 0: m_valid, m_data, m_row, m_col, m_last, frame_done, overflow, seq_err, busy.
  - Reset mid-frame or mid-drain discards all buffered data; there is no partial flush.
- Capture (write side): every cycle with sa_out_en=1 is one element.
  - Entry written = {sa_data, row=sa_row_out, col=col_cnt, last=(elem_cnt==15)}.
  - col_cnt (2 bit) and elem_cnt (4 bit) increment and wrap naturally; elem_cnt 15->0 starts a new frame.
  - A cycle with sa_out_en=0 holds both counters. A gap mid-frame is legal; there is no timeout.
- Sequence check: if sa_out_en=1 and sa_row_out != elem_cnt[3:2], set seq_err.
  - seq_err stays set until reset.
  - The entry is still written and tagged with sa_row_out.
- State machine: IDLE -> COLLECT on the first sa_out_en=1. COLLECT -> IDLE in the cycle the elem_cnt==15 write occurs.
- busy = (state==COLLECT) | (fifo_count!=0) | sa_out_en.
- FIFO push/pop rules:
  - Push is accepted when not full, or when a pop happens in the same cycle (full with a simultaneous pop: count stays DEPTH).
  - Push while full with no pop drops the element and sets overflow, which stays set until reset. Counters still advance, so later tags stay correct.
  - Simultaneous push and pop when empty: the entry lands normally and is visible the next cycle (no bypass).
- Output side:
  - Latency: an element written at edge k gives m_valid=1 from cycle k+1.
  - m_valid = FIFO non-empty. m_data, m_row, m_col and m_last come from the FIFO head.
  - All m_* outputs hold stable while m_valid & !m_ready.
  - Pop on m_valid & m_ready.
  - frame_done is registered: it pulses 1 cycle after a handshake with m_last=1.
- A new frame may be captured while the previous one is still draining; ordering is strictly FIFO.
- Arithmetic: counters are unsigned with modulo wrap. FIFO count is $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits with wrap.

Decomposition:
- Shared package sa_pkg:
  - N, DW.
  - typedef sa_idx_t (2-bit row/col index).
  - typedef sa_result_t struct {data, row, col, last}.
  - FRAME_ELEMS = N*N.
  - Also holds the controller's state encodings (IDLE/LOAD/PUMP/OUT) so both sides share them.
- Sub-module sa_sync_fifo: parameterised width/depth synchronous FIFO with push/pop/full/empty/count, registered head output. It stores sa_result_t.
- Top level holds the counters, the state machine, the sticky flags and the frame_done register.

Test Plan:
- Nominal frame: m_ready=1; 16 cycles sa_out_en=1, row_out 0,0,0,0,1,...,3, data 100..115 -> m_* reproduces (r,c,data) = (0,0,100)..(3,3,115) in order, each 1 cycle after its write; m_last only on (3,3,115); frame_done pulses once, 1 cycle after that handshake; overflow=seq_err=0; busy drops the cycle after the last pop.
- Backpressure: m_ready=0 for the whole frame, then 1 -> FIFO reaches count 16 and overflow stays 0; 16 outputs drain in order; m_data stays stable while stalled.
- Overflow: m_ready=0, 17 strobes (frame + 1) -> overflow=1; the 17th element (row 0, col 0 of the next frame) is dropped; the first 16 are intact.
- Sequence error: present row_out=2 at element 4 -> seq_err=1 from the next cycle and stays set; the entry is output with m_row=2, m_col=0.
- Gap and back-to-back frames: 3-cycle sa_out_en gap after element 7, then two full frames with m_ready toggling 1/0 every cycle -> 32 elements out in order; m_last on elements 16 and 32; 2 frame_done pulses.
- Reset mid-drain: rstn=0 for 1 cycle with 8 entries buffered -> next cycle m_valid=0, busy=0, all flags 0; the next frame starts at (0,0).
